icache_fetch_controller: RTL
============================

Name: icache_fetch_controller

Overview:
- Direct-mapped, read-only instruction cache and fill controller between the IF stage and the slow 128-bit-block instruction memory (6-bit block address, BUSYWAIT handshake).
- Serves 32-bit instructions in zero cycles on a hit.
- On a miss, stalls the pipeline via BUSYWAIT, fetches the 16-byte block, installs it, then replays the lookup.
- Also provides cache flush and saturating hit/miss counters for performance bring-up.

Parameters:
ADDR_BITS, 10, CPU byte-address width; block offset = 4 bits, tag = ADDR_BITS-4-INDEX_BITS
INDEX_BITS, 3, log2(number of lines); 8 lines × 128 bits by default
CNT_BITS, 16, width of HIT_COUNT / MISS_COUNT

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  reset, synchronous, active-high
READ  in  1  CPU fetch request
ADDRESS  in  ADDR_BITS  CPU byte address (PC[ADDR_BITS-1:0]); [1:0] ignored, [3:2] word select, [INDEX_BITS+3:4] index, upper bits tag
INSTRUCTION  out  32  fetched instruction
BUSYWAIT  out  1  stall request to pipeline
FLUSH  in  1  invalidate all lines
MEM_READ  out  1  block read request to instruction memory
MEM_ADDRESS  out  ADDR_BITS-4  block address {tag,index}
MEM_READINST  in  128  block data; byte 0 at bits [7:0]
MEM_BUSYWAIT  in  1  memory busy
HIT_COUNT  out  CNT_BITS  saturating hit counter
MISS_COUNT  out  CNT_BITS  saturating miss counter

Behaviour:
- Storage per line: valid bit, tag, 128-bit data. hit = READ & valid[index] & (tag[index]==ADDRESS tag) & state==IDLE.
- INSTRUCTION (combinational) = data[index][32*ADDRESS[3:2] +: 32] when hit, else 32'h0. Word 0 = bits [31:0].
- BUSYWAIT (combinational):
  - 0 while RESET=1.
  - In IDLE: (READ & !hit) | FLUSH.
  - 1 in MEM_READ and UPDATE.
- FSM states:
  - IDLE:
    - FLUSH=1 → clear all valid bits at the edge; stay IDLE. FLUSH has priority over a miss.
    - Else READ & !hit → latch {tag,index} into MEM_ADDRESS; MISS_COUNT+1; → MEM_READ.
    - READ & hit at an edge → HIT_COUNT+1.
  - MEM_READ:
    - MEM_READ=1; MEM_ADDRESS held.
    - Minimum 1 cycle. At first posedge after entry where MEM_BUSYWAIT==0: write MEM_READINST into data[index], set tag, valid=1; MEM_READ=0 after the edge; → UPDATE.
  - UPDATE: one cycle, BUSYWAIT=1, no memory request; → IDLE. The lookup replays in IDLE and hits if ADDRESS is unchanged.
- Fill address is the latched value. ADDRESS changes during a miss do not corrupt the fill; the new address is looked up normally in IDLE.
- Miss latency: stall cycles = N+2, where N = number of cycles spent in MEM_READ.
- FLUSH outside IDLE: recorded as flush_pending. In UPDATE all valid bits clear, including the just-filled line; flush_pending is then cleared.
- Counters: saturate at all-ones and do not wrap. A hit and a miss are never counted at the same edge.
- RESET (any state, incl. mid-fill): next edge forces
  - state=IDLE, all valid=0, flush_pending=0
  - MEM_READ=0, MEM_ADDRESS=0, HIT_COUNT=0, MISS_COUNT=0
  - An in-flight memory response is discarded.
- Tag and data arrays are not reset; only valid bits are cleared.

Test Plan:
- Cold miss: memory model with 3-cycle busy and block 0 words {0x00C00293, 0x00500313, 0x00C00213, 0x00006033}; READ=1, ADDRESS=0x000 → BUSYWAIT=1 immediately; MEM_READ=1 with MEM_ADDRESS=0x00; after N+2 cycles BUSYWAIT=0, INSTRUCTION=0x00C00293, MISS_COUNT=1.
- Same-block hits: ADDRESS 0x004, 0x008, 0x00C on consecutive cycles → BUSYWAIT=0 each cycle; INSTRUCTION = 0x00500313, 0x00C00213, 0x00006033; HIT_COUNT advances by 3; MEM_READ stays 0.
- Conflict eviction: after the above, ADDRESS=0x080 (tag 1, index 0) → miss with MEM_ADDRESS=0x08; then ADDRESS=0x000 → miss again with MEM_ADDRESS=0x00; MISS_COUNT=3.
- Flush: cache warm at 0x000; FLUSH=1 for one cycle in IDLE with READ=1 → BUSYWAIT=1 that cycle, no MEM_READ. Next cycle 0x000 misses. Repeat with FLUSH pulsed mid-MEM_READ → after UPDATE the lookup misses again.
- Reset mid-fill: assert RESET during cycle 2 of MEM_READ → after the edge MEM_READ=0, counters=0; the memory returning data later writes nothing; 0x000 then misses.
- Counter saturation: CNT_BITS=4, 20 consecutive hits → HIT_COUNT holds 4'hF.

Source files
------------

// File: rtl/icache_fetch_controller_if.sv
// Bundles the CPU fetch port and the instruction-memory block port of the
// instruction cache into one interface.
//   slave  : the cache (receives fetch requests, issues block reads)
//   master : the environment (CPU fetch stage plus instruction memory)
// CPU side : READ, ADDRESS, FLUSH -> ; <- INSTRUCTION, BUSYWAIT
// Memory   : <- MEM_READ, MEM_ADDRESS ; MEM_READINST, MEM_BUSYWAIT ->
// Perf     : <- HIT_COUNT, MISS_COUNT
interface icache_fetch_controller_if #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned CNT_BITS  = 16
);
    localparam int unsigned BLK_BITS = ADDR_BITS - 4;

    logic                 READ;
    logic [ADDR_BITS-1:0] ADDRESS;
    logic [31:0]          INSTRUCTION;
    logic                 BUSYWAIT;
    logic                 FLUSH;
    logic                 MEM_READ;
    logic [BLK_BITS-1:0]  MEM_ADDRESS;
    logic [127:0]         MEM_READINST;
    logic                 MEM_BUSYWAIT;
    logic [CNT_BITS-1:0]  HIT_COUNT;
    logic [CNT_BITS-1:0]  MISS_COUNT;

    modport slave (
        input  READ, ADDRESS, FLUSH, MEM_READINST, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
    );

    modport master (
        output READ, ADDRESS, FLUSH, MEM_READINST, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/icache_fetch_controller.sv
// Direct-mapped read-only instruction cache with block fill controller.
// Hits return a 32-bit instruction combinationally; misses stall via BUSYWAIT,
// fetch a 128-bit block, install it and replay the lookup. Supports flush and
// saturating hit/miss counters.
// Ports:
//   CLK   : clock, all state updates on posedge
//   RESET : synchronous, active-high
//   bus   : icache_fetch_controller_if.slave (CPU fetch port, memory block
//           port, performance counters)
module icache_fetch_controller #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    icache_fetch_controller_if.slave   bus
);
    localparam int unsigned BLK_BITS = ADDR_BITS - 4;
    localparam int unsigned TAG_BITS = BLK_BITS - INDEX_BITS;
    localparam int unsigned LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [127:0]          data_q [LINES];
    logic                  flush_pending_q, flush_pending_d;
    logic                  mem_read_q, mem_read_d;
    logic [BLK_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_BITS-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_BITS-1:0]   miss_cnt_q, miss_cnt_d;
    logic                  fill_c;

    logic [INDEX_BITS-1:0] idx_c;
    logic [TAG_BITS-1:0]   tag_c;
    logic [1:0]            word_c;
    logic [INDEX_BITS-1:0] fill_idx_c;
    logic [TAG_BITS-1:0]   fill_tag_c;
    logic                  hit_c;
    logic                  unused_addr_bits;

    // Address decode of the live CPU request and of the latched fill address
    assign idx_c      = bus.ADDRESS[INDEX_BITS+3:4];
    assign tag_c      = bus.ADDRESS[ADDR_BITS-1:INDEX_BITS+4];
    assign word_c     = bus.ADDRESS[3:2];
    assign fill_idx_c = mem_addr_q[INDEX_BITS-1:0];
    assign fill_tag_c = mem_addr_q[BLK_BITS-1:INDEX_BITS];
    assign unused_addr_bits = ^bus.ADDRESS[1:0];

    // Lookups only hit in IDLE so a fill never serves a stale word mid-update
    assign hit_c = bus.READ && valid_q[idx_c] && (tag_q[idx_c] == tag_c) && (state_q == S_IDLE);

    assign bus.INSTRUCTION = hit_c ? data_q[idx_c][{word_c, 5'd0} +: 32] : 32'h0;

    always_comb begin
        bus.BUSYWAIT = 1'b1;
        if (RESET) begin
            bus.BUSYWAIT = 1'b0;
        end else if (state_q == S_IDLE) begin
            bus.BUSYWAIT = (bus.READ && !hit_c) || bus.FLUSH;
        end
    end

    assign bus.MEM_READ    = mem_read_q;
    assign bus.MEM_ADDRESS = mem_addr_q;
    assign bus.HIT_COUNT   = hit_cnt_q;
    assign bus.MISS_COUNT  = miss_cnt_q;

    // Next-state, fill strobe and counter updates; reset is folded in here
    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        flush_pending_d = flush_pending_q;
        mem_read_d      = mem_read_q;
        mem_addr_d      = mem_addr_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        fill_c          = 1'b0;

        if (RESET) begin
            state_d         = S_IDLE;
            valid_d         = '0;
            flush_pending_d = 1'b0;
            mem_read_d      = 1'b0;
            mem_addr_d      = '0;
            hit_cnt_d       = '0;
            miss_cnt_d      = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.FLUSH) begin
                        // Flush wins over a miss; a hit in the same cycle is stalled, not counted
                        valid_d = '0;
                    end else if (bus.READ && !hit_c) begin
                        mem_addr_d = {tag_c, idx_c};
                        mem_read_d = 1'b1;
                        state_d    = S_MEM_READ;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
                    end else if (hit_c) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_BITS'(1);
                    end
                end
                S_MEM_READ: begin
                    if (bus.FLUSH) flush_pending_d = 1'b1;
                    if (!bus.MEM_BUSYWAIT) begin
                        fill_c              = 1'b1;
                        valid_d[fill_idx_c] = 1'b1;
                        mem_read_d          = 1'b0;
                        state_d             = S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    // A deferred flush also drops the line just installed
                    if (flush_pending_q || bus.FLUSH) valid_d = '0;
                    flush_pending_d = 1'b0;
                    state_d         = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge CLK) begin
        state_q         <= state_d;
        valid_q         <= valid_d;
        flush_pending_q <= flush_pending_d;
        mem_read_q      <= mem_read_d;
        mem_addr_q      <= mem_addr_d;
        hit_cnt_q       <= hit_cnt_d;
        miss_cnt_q      <= miss_cnt_d;
    end

    // Tag and data arrays, written only on a completed fill
    always_ff @(posedge CLK) begin
        if (fill_c) begin
            data_q[fill_idx_c] <= bus.MEM_READINST;
            tag_q[fill_idx_c]  <= fill_tag_c;
        end
    end
endmodule
